fetch_buffer: RTL and testbench

Decoupling instruction queue between fetch and decode. Accepts completed fetch results (PC, instruction word, ID, fault status), pre-decodes control-flow class, and presents entries in order to decode with a valid/ack handshake. Issues a credit signal that gates new fetch requests, so that every in-flight fetch always has a guaranteed slot. Clears on fetch flush.

---
 rtl/fetch_buffer.sv | 120 ++++++++++++
 tb/tb_fetch_buffer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer: in-order instruction queue between fetch and decode.
// Stores completed fetch results with pre-decoded control-flow flags and
// hands them to decode over a valid/ack handshake. The fetch_credit output
// guarantees a free slot for every request fetch may still have in flight.
module fetch_buffer #(
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 2,
    parameter int ID_W         = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            fetch_valid,
    input  logic [31:0]     fetch_pc,
    input  logic [31:0]     fetch_instruction,
    input  logic [ID_W-1:0] fetch_id,
    input  logic            fetch_ok,
    input  logic [4:0]      fetch_error_code,
    output logic            fetch_credit,
    output logic            dec_valid,
    input  logic            dec_ack,
    output logic [31:0]     dec_pc,
    output logic [31:0]     dec_instruction,
    output logic [ID_W-1:0] dec_id,
    output logic            dec_ok,
    output logic [4:0]      dec_error_code,
    output logic            dec_is_branch,
    output logic            dec_is_jal,
    output logic            dec_is_jalr,
    output logic            dec_illegal_len,
    output logic            overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] LP_INFL  = (AW+1)'(MAX_INFLIGHT);

    // Entry storage; flags are {illegal_len, jalr, jal, branch}
    logic [31:0]     r_pc    [DEPTH];
    logic [31:0]     r_instr [DEPTH];
    logic [ID_W-1:0] r_id    [DEPTH];
    logic            r_ok    [DEPTH];
    logic [4:0]      r_ec    [DEPTH];
    logic [3:0]      r_pd    [DEPTH];

    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [AW:0]   w_free;
    logic [4:0]    w_opc;
    logic [3:0]    w_pd;

    assign w_full = (r_count == LP_DEPTH);
    assign w_free = LP_DEPTH - r_count;

    assign dec_valid = (r_count != '0);
    // A pop frees a slot at the same edge, so a full buffer still accepts a push
    assign w_pop  = dec_valid & dec_ack & ~flush;
    assign w_push = fetch_valid & ~flush & (~w_full | w_pop);
    assign w_drop = fetch_valid & ~flush & w_full & ~w_pop;

    // Credit uses the registered count only; a same-cycle pop is not counted
    assign fetch_credit = (w_free >= LP_INFL) & ~flush;

    // Pre-decode of the incoming word; a faulted fetch carries no flags
    assign w_opc = fetch_instruction[6:2];
    assign w_pd  = {4{fetch_ok}} & {
        (fetch_instruction[1:0] != 2'b11),
        (w_opc == 5'b11001),
        (w_opc == 5'b11011),
        (w_opc == 5'b11000)
    };

    // Write the pushed entry at the tail
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_wr_ptr]    <= fetch_pc;
            r_instr[r_wr_ptr] <= fetch_instruction;
            r_id[r_wr_ptr]    <= fetch_id;
            r_ok[r_wr_ptr]    <= fetch_ok;
            r_ec[r_wr_ptr]    <= fetch_error_code;
            r_pd[r_wr_ptr]    <= w_pd;
        end
    end

    // Pointer and occupancy tracking; flush empties the queue
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // Sticky record of a dropped push; only reset clears it
    always_ff @(posedge clk) begin
        if (rst)         r_overflow <= 1'b0;
        else if (w_drop) r_overflow <= 1'b1;
    end

    assign overflow        = r_overflow;
    assign dec_pc          = r_pc[r_rd_ptr];
    assign dec_instruction = r_instr[r_rd_ptr];
    assign dec_id          = r_id[r_rd_ptr];
    assign dec_ok          = r_ok[r_rd_ptr];
    assign dec_error_code  = r_ec[r_rd_ptr];
    assign dec_is_branch   = r_pd[r_rd_ptr][0];
    assign dec_is_jal      = r_pd[r_rd_ptr][1];
    assign dec_is_jalr     = r_pd[r_rd_ptr][2];
    assign dec_illegal_len = r_pd[r_rd_ptr][3];
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: scoreboard bench for fetch_buffer (DEPTH=4, MAX_INFLIGHT=2).
// Accepted pushes enter a queue model; the head is compared every cycle.
module tb_fetch_buffer;
    localparam int DEPTH = 4;
    localparam int MAXI  = 2;
    localparam int ID_W  = 3;

    logic            clk = 1'b0;
    logic            rst, flush, fetch_valid, fetch_ok, dec_ack;
    logic [31:0]     fetch_pc, fetch_instruction;
    logic [ID_W-1:0] fetch_id;
    logic [4:0]      fetch_error_code;
    logic            fetch_credit, dec_valid, dec_ok, overflow;
    logic [31:0]     dec_pc, dec_instruction;
    logic [ID_W-1:0] dec_id;
    logic [4:0]      dec_error_code;
    logic            dec_is_branch, dec_is_jal, dec_is_jalr, dec_illegal_len;

    fetch_buffer #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAXI), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .fetch_instruction(fetch_instruction), .fetch_id(fetch_id),
        .fetch_ok(fetch_ok), .fetch_error_code(fetch_error_code),
        .fetch_credit(fetch_credit), .dec_valid(dec_valid), .dec_ack(dec_ack),
        .dec_pc(dec_pc), .dec_instruction(dec_instruction), .dec_id(dec_id),
        .dec_ok(dec_ok), .dec_error_code(dec_error_code),
        .dec_is_branch(dec_is_branch), .dec_is_jal(dec_is_jal),
        .dec_is_jalr(dec_is_jalr), .dec_illegal_len(dec_illegal_len),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     pc;
        logic [31:0]     ins;
        logic [ID_W-1:0] id;
        logic            ok;
        logic [4:0]      ec;
    } ent_t;

    ent_t q[$];
    logic m_ovf;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Compare DUT outputs against the model head (inputs idle)
    task automatic check_state();
        ent_t h;
        logic [4:0] op;
        chk("dec_valid", dec_valid, q.size() != 0);
        chk("credit", fetch_credit, (DEPTH - q.size()) >= MAXI);
        chk("overflow", overflow, m_ovf);
        if (q.size() != 0) begin
            h  = q[0];
            op = h.ins[6:2];
            chk("dec_pc", dec_pc, h.pc);
            chk("dec_ins", dec_instruction, h.ins);
            chk("dec_id", dec_id, h.id);
            chk("dec_ok", dec_ok, h.ok);
            chk("dec_ec", dec_error_code, h.ec);
            chk("is_branch", dec_is_branch, h.ok && op == 5'h18);
            chk("is_jal", dec_is_jal, h.ok && op == 5'h1B);
            chk("is_jalr", dec_is_jalr, h.ok && op == 5'h19);
            chk("illegal_len", dec_illegal_len, h.ok && h.ins[1:0] != 2'b11);
        end
    endtask

    task automatic idle();
        rst = 0; flush = 0; fetch_valid = 0; dec_ack = 0; fetch_ok = 1;
        fetch_pc = '0; fetch_instruction = '0; fetch_id = '0; fetch_error_code = '0;
    endtask

    // One cycle: check, drive, model the edge, return to idle at negedge
    task automatic cyc(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [ID_W-1:0] id, input logic ok, input logic [4:0] ec,
                       input logic ack, input logic fl);
        ent_t e;
        logic pop, full;
        check_state();
        fetch_valid = fv; fetch_pc = pc; fetch_instruction = ins; fetch_id = id;
        fetch_ok = ok; fetch_error_code = ec; dec_ack = ack; flush = fl;
        #1;
        if (fl) chk("flush_credit", fetch_credit, 1'b0);
        e = '{pc: pc, ins: ins, id: id, ok: ok, ec: ec};
        @(posedge clk);
        if (fl) q.delete();
        else begin
            pop  = (q.size() != 0) && ack;
            full = (q.size() == DEPTH);
            if (fv && full && !pop) m_ovf = 1'b1;
            if (pop) void'(q.pop_front());
            if (fv && (!full || pop)) q.push_back(e);
        end
        #1 idle();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ins, input logic [ID_W-1:0] id);
        cyc(1, pc, ins, id, 1, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle(); rst = 1;
        @(posedge clk);
        q.delete(); m_ovf = 0;
        #1 rst = 0;
        @(negedge clk);
    endtask

    initial begin
        int nid;
        logic fv, ack;
        m_ovf = 0;
        do_reset();
        chk("rst_valid", dec_valid, 1'b0);
        chk("rst_credit", fetch_credit, 1'b1);
        chk("rst_ovf", overflow, 1'b0);

        // First push: BEQ visible the next cycle
        push(32'h8000_0000, 32'h0000_0063, 3'd1);
        chk("t1_valid", dec_valid, 1'b1);
        chk("t1_pc", dec_pc, 32'h8000_0000);
        chk("t1_branch", dec_is_branch, 1'b1);
        chk("t1_jal", dec_is_jal, 1'b0);
        chk("t1_id", dec_id, 3'd1);

        // Fill: credit drops at count 3, overflow on 5th push
        push(32'h8000_0004, 32'h0000_006F, 3'd2);
        chk("t2_credit_c2", fetch_credit, 1'b1);
        push(32'h8000_0008, 32'h0000_0067, 3'd3);
        chk("t2_credit_c3", fetch_credit, 1'b0);
        push(32'h8000_000C, 32'h0000_0001, 3'd4);
        push(32'h8000_0010, 32'h0000_0013, 3'd5);
        chk("t2_ovf", overflow, 1'b1);
        chk("t2_head", dec_id, 3'd1);
        check_state();

        // Full with simultaneous push and ack
        do_reset();
        for (int i = 1; i <= 4; i++) push(32'h100 + 4*i, 32'h0000_0013, 3'(i));
        cyc(1, 32'h200, 32'h0000_0063, 3'd5, 1, 0, 1, 0);
        chk("t3_ovf", overflow, 1'b0);
        chk("t3_credit_full", fetch_credit, 1'b0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 1, 0);
        chk("t3_id5", dec_id, 3'd5);
        chk("t3_branch5", dec_is_branch, 1'b1);

        // Faulted fetch carries no flags
        do_reset();
        cyc(1, 32'h300, 32'h0000_006F, 3'd2, 0, 5'd1, 0, 0);
        chk("t4_ok", dec_ok, 1'b0);
        chk("t4_ec", dec_error_code, 5'd1);
        chk("t4_jal", dec_is_jal, 1'b0);
        chk("t4_ins", dec_instruction, 32'h0000_006F);

        // Flush together with push and ack
        do_reset();
        for (int i = 0; i < 3; i++) push(32'h400 + 4*i, 32'h0000_0067, 3'(i));
        cyc(1, 32'h500, 32'h0000_0063, 3'd7, 1, 0, 1, 1);
        chk("t5_valid", dec_valid, 1'b0);
        chk("t5_credit", fetch_credit, 1'b1);
        push(32'h600, 32'h0000_0013, 3'd6);
        chk("t5_next_id", dec_id, 3'd6);

        // Random traffic honouring credit
        do_reset();
        nid = 0;
        for (int c = 0; c < 1000; c++) begin
            fv  = fetch_credit && ($urandom_range(1) == 1);
            ack = ($urandom_range(1) == 1);
            cyc(fv, $urandom, {$urandom_range(32'hFFFF_FFFF) >> 7, 7'($urandom)},
                3'(nid), ($urandom_range(7) != 0), 5'($urandom), ack, 0);
            if (fv) nid++;
        end
        chk("rand_ovf", overflow, 1'b0);
        check_state();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
